// File: rtl/exp_product_if.sv
`default_nettype none
// ============================================================================
// exp_product_if : term-code job handshake and result/status bundle
// Revision 1.0
// ============================================================================
interface exp_product_if;
  logic        mul_valid;
  logic [5:0]  multiplier_0;
  logic [5:0]  multiplier_1;
  logic [5:0]  multiplier_2;
  logic [5:0]  multiplier_3;
  logic [5:0]  multiplier_4;
  logic [5:0]  multiplier_5;
  logic [25:0] exp_result;
  logic        exp_valid;
  logic        exp_sat;
  logic        code_err;
  logic        busy;
  logic        in_drop;

  modport master (
    output mul_valid, multiplier_0, multiplier_1, multiplier_2,
           multiplier_3, multiplier_4, multiplier_5,
    input  exp_result, exp_valid, exp_sat, code_err, busy, in_drop
  );

  modport slave (
    input  mul_valid, multiplier_0, multiplier_1, multiplier_2,
           multiplier_3, multiplier_4, multiplier_5,
    output exp_result, exp_valid, exp_sat, code_err, busy, in_drop
  );
endinterface
`default_nettype wire

// File: rtl/exp_product.sv
`default_nettype none
// ============================================================================
// exp_product : rebuilds e^X as a product of six LUT factors, Q15.11 result
// Revision 1.0
// ============================================================================
module exp_product (
  input  wire logic    clk,
  input  wire logic    rst_n,
  exp_product_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_MUL  = 3'b010,
    ST_DONE = 3'b100
  } state_t;

  localparam logic [25:0] C_ONE     = 26'd2048;
  localparam logic [25:0] C_ACC_MAX = 26'h3FFFFFF;
  localparam logic [2:0]  C_LAST    = 3'd5;

  // Returns {illegal, factor}; illegal and empty codes both multiply by 1.0
  function automatic logic [26:0] f_decode(input logic [5:0] code);
    logic [25:0] fac;
    logic        err;
    fac = C_ONE;
    err = 1'b0;
    if (code[5]) begin
      case (code[4:0])
        5'd0:    fac = 26'd5567;
        5'd1:    fac = 26'd15133;
        5'd2:    fac = 26'd111817;
        5'd3:    fac = 26'd6105002;
        default: err = 1'b1;
      endcase
    end else begin
      case (code[4:0])
        5'd0:    fac = C_ONE;
        5'd1:    fac = 26'd3377;
        5'd2:    fac = 26'd2630;
        5'd3:    fac = 26'd2321;
        5'd4:    fac = 26'd2180;
        5'd5:    fac = 26'd2113;
        5'd6:    fac = 26'd2080;
        5'd7:    fac = 26'd2064;
        5'd8:    fac = 26'd2056;
        5'd9:    fac = 26'd2052;
        5'd10:   fac = 26'd2050;
        5'd11:   fac = 26'd2049;
        default: err = 1'b1;
      endcase
    end
    return {err, fac};
  endfunction

  state_t      r_state;
  state_t      w_next;
  logic        w_load;
  logic        w_step;
  logic        w_done;

  logic [5:0]  r_codes [6];
  logic [2:0]  r_cnt;
  logic [25:0] r_acc;
  logic        r_sat;
  logic        r_err;

  logic [25:0] r_result;
  logic        r_valid;
  logic        r_osat;
  logic        r_oerr;
  logic        r_drop;

  logic [26:0] w_dec;
  logic [25:0] w_factor;
  logic        w_code_err;
  logic [51:0] w_prod;
  logic [40:0] w_prod_hi;
  logic        w_ovf;
  logic [25:0] w_acc_mul;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    w_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.mul_valid) begin
          w_load = 1'b1;
          w_next = ST_MUL;
        end
      end
      ST_MUL: begin
        w_step = 1'b1;
        if (r_cnt == C_LAST) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_dec      = f_decode(r_codes[r_cnt]);
  assign w_factor   = w_dec[25:0];
  assign w_code_err = w_dec[26];
  assign w_prod     = {26'd0, r_acc} * {26'd0, w_factor};
  // Drop the 11 fraction bits of the product; anything above bit 25 is overflow
  assign w_prod_hi  = 41'(w_prod >> 11);
  assign w_ovf      = |w_prod_hi[40:26];
  assign w_acc_mul  = w_prod_hi[25:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_codes  <= '{default: '0};
      r_cnt    <= '0;
      r_acc    <= '0;
      r_sat    <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_osat   <= 1'b0;
      r_oerr   <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_drop  <= bus.mul_valid && (r_state != ST_IDLE);

      if (w_load) begin
        r_codes[0] <= bus.multiplier_0;
        r_codes[1] <= bus.multiplier_1;
        r_codes[2] <= bus.multiplier_2;
        r_codes[3] <= bus.multiplier_3;
        r_codes[4] <= bus.multiplier_4;
        r_codes[5] <= bus.multiplier_5;
        r_acc      <= C_ONE;
        r_cnt      <= '0;
        r_sat      <= 1'b0;
        r_err      <= 1'b0;
      end

      if (w_step) begin
        r_cnt <= r_cnt + 3'd1;
        // Saturation is sticky so later small factors cannot pull acc back down
        if (r_sat || w_ovf) begin
          r_acc <= C_ACC_MAX;
          r_sat <= 1'b1;
        end else begin
          r_acc <= w_acc_mul;
        end
        if (w_code_err) r_err <= 1'b1;
      end

      if (w_done) begin
        r_result <= r_acc;
        r_osat   <= r_sat;
        r_oerr   <= r_err;
        r_valid  <= 1'b1;
      end
    end
  end

  assign bus.exp_result = r_result;
  assign bus.exp_valid  = r_valid;
  assign bus.exp_sat    = r_osat;
  assign bus.code_err   = r_oerr;
  assign bus.in_drop    = r_drop;
  assign bus.busy       = (r_state == ST_MUL) || (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: doc/exp_product.md
# exp_product

Consumer end of the exponent decomposition interface. Accepts the six 6-bit term codes and the `mul_valid` pulse produced by the decomposition stage. It rebuilds e^X as the product of per-term constants e^(term), taken from a fixed LUT, using one multiply per cycle. It returns a Q15.11 result with a single-cycle valid strobe and status flags.

## Interface
- No parameters; all widths fixed.
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `mul_valid`  in  1  single-cycle pulse; `multiplier_0`..`multiplier_5` valid in the same cycle.
- `multiplier_0`..`multiplier_5`  in  6 each  term code `{int_or_fra, i[4:0]}`; index 0 is applied first.
- `exp_result`  out  26  e^X in Q15.11 (15 integer, 11 fraction bits), unsigned; held until the next result.
- `exp_valid`  out  1  single-cycle pulse when `exp_result` and the flags update.
- `exp_sat`  out  1  result saturated; valid with `exp_valid`, held after.
- `code_err`  out  1  at least one illegal code in the job; valid with `exp_valid`, held after.
- `busy`  out  1  high in MUL and DONE.
- `in_drop`  out  1  single-cycle pulse: `mul_valid` arrived while `busy`.

## Operation
- Code decode:
  - `{1,i}` with i=0..3 means term 2^i.
  - `{0,i}` with i=1..11 means term 2^-i.
  - `{0,0}` means empty (factor 1.0).
  - Any other code is illegal: factor 1.0, and it sets the job's `code_err`.
- LUT factors, Q15.11, round-to-nearest:
  - Integer terms: e^1=5567, e^2=15133, e^4=111817, e^8=6105002.
  - Fractional terms, i=1..11: 3377, 2630, 2321, 2180, 2113, 2080, 2064, 2056, 2052, 2050, 2049.
  - Factor 1.0 = 2048.
- Accumulator `acc` is 26 bits.
- Multiply step: p = acc × factor (52 bits); new acc = p[36:11], truncated.
  - If p[51:37] ≠ 0, acc becomes 26'h3FFFFFF and the job's sat flag is set.
  - Sat is sticky within a job: once set, later steps leave acc at max.
- FSM states, one-hot: IDLE, MUL, DONE.
  - IDLE: if `mul_valid`, latch all six codes, acc←2048, cnt←0, clear job sat/err flags, go to MUL.
  - MUL: multiply by the factor for code[cnt], cnt←cnt+1. When cnt==5 on this edge, go to DONE. Exactly 6 steps always; empty codes cost a cycle.
  - DONE: `exp_result`←acc, `exp_sat`/`code_err`←job flags, `exp_valid`←1, go to IDLE.
- Busy handling:
  - `mul_valid` in MUL or DONE is ignored; `in_drop` pulses next cycle. The current job is unaffected.
  - `mul_valid` in the first IDLE cycle after DONE is accepted.
- Reset (any state, including mid-job):
  - State←IDLE, cnt/acc/latched codes cleared.
  - All outputs←0; no `exp_valid` for the aborted job.

## Timing
- Edge E0 samples `mul_valid` (IDLE); E1..E6 are the MUL steps; E7 is DONE.
- `exp_valid` is high in the cycle after E7: latency is 7 clocks from the sampling edge.
- Earliest next accept is E8, giving a throughput of one job per 8 cycles.
- `busy` is high from after E0 until after E7.
- `exp_valid` and `in_drop` are never high for more than one cycle.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
- All six codes 0 (X=0) -> `exp_result`=2048, `exp_sat`=0, `code_err`=0, `exp_valid` exactly 7 cycles after the sampling edge.
- Codes {1,0}, then 0×5 (X=1.0) -> `exp_result`=5567. Codes {0,1},{0,1}, then 0×4 -> `exp_result`=5568 (3377²>>11).
- Codes {1,3},{1,3}, then 0×4 -> first step gives 6105002; second overflows -> `exp_result`=26'h3FFFFFF, `exp_sat`=1. The next job with all zeros returns 2048 and `exp_sat`=0.
- Code {1,5} or {0,12} in slot 2, others 0 -> factor 1.0, `exp_result`=2048, `code_err`=1.
- Second `mul_valid` 3 cycles after the first -> `in_drop` pulses once, the first result is unchanged, and no second `exp_valid`. A `mul_valid` exactly one cycle after `exp_valid` is accepted.
- `rst_n` low for 1 cycle at E3 -> no `exp_valid`, all outputs 0. A job issued after reset completes normally.
